slot_stop_sequencer: RTL

Top-level controller that sequences the three reels of the slot machine.
- Turns one front-panel button into a run/stop sequence.
- On a stop request, halts reels 1→3 one at a time with a programmable stagger and latches each stopped digit.
- Evaluates the result and drives the buzzer for a fixed time on a win.
- Sits between the button/rst inputs and the per-reel slot counters; its outputs gate those counters and feed the display encoder.

---
 rtl/slot_pkg.sv | 20 ++
 rtl/button_edge.sv | 43 ++++
 rtl/slot_stop_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/slot_pkg.sv
// Shared types and constants for the slot machine reel sequencer.
// Contents:
//   NUM_REELS       - number of reels on the machine
//   DIGIT_W_DEFAULT - default width of one reel digit (values 0-9)
//   seq_state_t     - sequencer FSM state; also exported to the display encoder
package slot_pkg;

  localparam int NUM_REELS       = 3;
  localparam int DIGIT_W_DEFAULT = 4;

  typedef enum logic [2:0] {
    SET    = 3'd0,
    RUN    = 3'd1,
    STOP1  = 3'd2,
    STOP2  = 3'd3,
    STOP3  = 3'd4,
    RESULT = 3'd5
  } seq_state_t;

endpackage

// File: rtl/button_edge.sv
// Button conditioner: two-flop synchronizer followed by a registered
// rising-edge detector. Usable for any front-panel push button.
// Ports:
//   clk       in  system clock
//   rst       in  asynchronous active-low reset
//   button    in  raw button level, asynchronous to clk, active-high
//   btn_pulse out one-clk pulse, asserted on the 3rd clk edge after button rises
module button_edge (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic btn_pulse
);

  logic       sync1_r;
  logic       sync2_r;
  logic       prev_r;
  logic       pulse_r;
  // fill_r[1] marks that sync2_r holds a real button sample rather than
  // its reset value; until then prev_r is forced high so a button held
  // through reset release cannot fake a rising edge.
  logic [1:0] fill_r;

  // synchronizer, edge history and pulse register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_r  <= 2'b00;
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      fill_r  <= {fill_r[0], 1'b1};
      sync1_r <= button;
      sync2_r <= sync1_r;
      prev_r  <= fill_r[1] ? sync2_r : 1'b1;
      pulse_r <= fill_r[1] & sync2_r & ~prev_r;
    end
  end

  assign btn_pulse = pulse_r;

endmodule

// File: rtl/slot_stop_sequencer.sv
// Slot machine run/stop sequencer. One button starts all reels, the next
// press stops reels 1..3 one at a time with a programmable stagger while
// latching each stopped digit, then the result is evaluated and the buzzer
// is driven for a fixed time on a win.
// Ports:
//   clk       in  system clock (50 MHz)
//   rst       in  asynchronous active-low reset
//   button    in  raw front-panel button, asynchronous, active-high
//   reel_val  in  live digit of each reel, index 0 = reel 1
//   reel_en   out per-reel run enable, 1 = spinning
//   held_val  out latched stopped digit per reel
//   win       out all three held digits equal, valid in RESULT
//   buzzer    out win annunciator
//   state     out current sequencer state for the display encoder
module slot_stop_sequencer
  import slot_pkg::*;
#(
  parameter int STAGGER_CYC = 25_000_000,
  parameter int BUZZ_CYC    = 50_000_000,
  parameter int DIGIT_W     = DIGIT_W_DEFAULT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                button,
  input  logic [NUM_REELS-1:0][DIGIT_W-1:0]   reel_val,
  output logic [NUM_REELS-1:0]                reel_en,
  output logic [NUM_REELS-1:0][DIGIT_W-1:0]   held_val,
  output logic                                win,
  output logic                                buzzer,
  output seq_state_t                          state
);

  localparam int STG_W = $clog2(STAGGER_CYC + 1);
  localparam int BUZ_W = $clog2(BUZZ_CYC + 1);
  localparam logic [STG_W-1:0] STG_LOAD = STG_W'(STAGGER_CYC - 1);
  localparam logic [BUZ_W-1:0] BUZ_LOAD = BUZ_W'(BUZZ_CYC - 1);
  localparam logic [STG_W-1:0] STG_ONE  = STG_W'(1);
  localparam logic [BUZ_W-1:0] BUZ_ONE  = BUZ_W'(1);
  localparam logic [STG_W-1:0] STG_ZERO = {STG_W{1'b0}};
  localparam logic [BUZ_W-1:0] BUZ_ZERO = {BUZ_W{1'b0}};

  // Full-width equality of the three latched digits.
  function automatic logic digits_match(
    input logic [NUM_REELS-1:0][DIGIT_W-1:0] d
  );
    return (d[0] == d[1]) && (d[1] == d[2]);
  endfunction

  logic                              btn_pulse_s;
  seq_state_t                        state_r,   state_nxt_s;
  logic [NUM_REELS-1:0]              reel_en_r, reel_en_nxt_s;
  logic [NUM_REELS-1:0][DIGIT_W-1:0] held_r,    held_nxt_s;
  logic                              win_r,     win_nxt_s;
  logic                              buzz_r,    buzz_nxt_s;
  logic [STG_W-1:0]                  stg_cnt_r, stg_cnt_nxt_s;
  logic [BUZ_W-1:0]                  buz_cnt_r, buz_cnt_nxt_s;

  button_edge u_button_edge (
    .clk       (clk),
    .rst       (rst),
    .button    (button),
    .btn_pulse (btn_pulse_s)
  );

  // state and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= SET;
      reel_en_r <= 3'b000;
      held_r    <= '{default: {DIGIT_W{1'b0}}};
      win_r     <= 1'b0;
      buzz_r    <= 1'b0;
      stg_cnt_r <= STG_ZERO;
      buz_cnt_r <= BUZ_ZERO;
    end else begin
      state_r   <= state_nxt_s;
      reel_en_r <= reel_en_nxt_s;
      held_r    <= held_nxt_s;
      win_r     <= win_nxt_s;
      buzz_r    <= buzz_nxt_s;
      stg_cnt_r <= stg_cnt_nxt_s;
      buz_cnt_r <= buz_cnt_nxt_s;
    end
  end

  // next-state and next-output decode; presses in STOP1..STOP3 are dropped
  always_comb begin
    state_nxt_s   = state_r;
    reel_en_nxt_s = reel_en_r;
    held_nxt_s    = held_r;
    win_nxt_s     = win_r;
    buzz_nxt_s    = buzz_r;
    stg_cnt_nxt_s = stg_cnt_r;
    buz_cnt_nxt_s = buz_cnt_r;
    case (state_r)
      SET: begin
        if (btn_pulse_s) begin
          state_nxt_s   = RUN;
          reel_en_nxt_s = 3'b111;
        end else begin
          reel_en_nxt_s = 3'b000;
        end
      end
      RUN: begin
        if (btn_pulse_s) begin
          state_nxt_s   = STOP1;
          reel_en_nxt_s = 3'b110;
          held_nxt_s[0] = reel_val[0];
          stg_cnt_nxt_s = STG_LOAD;
        end else begin
          reel_en_nxt_s = 3'b111;
        end
      end
      STOP1: begin
        if (stg_cnt_r == STG_ZERO) begin
          state_nxt_s   = STOP2;
          reel_en_nxt_s = 3'b100;
          held_nxt_s[1] = reel_val[1];
          stg_cnt_nxt_s = STG_LOAD;
        end else begin
          stg_cnt_nxt_s = stg_cnt_r - STG_ONE;
        end
      end
      STOP2: begin
        if (stg_cnt_r == STG_ZERO) begin
          state_nxt_s   = STOP3;
          reel_en_nxt_s = 3'b000;
          held_nxt_s[2] = reel_val[2];
        end else begin
          stg_cnt_nxt_s = stg_cnt_r - STG_ONE;
        end
      end
      STOP3: begin
        // all digits are latched by now, so the result is known this edge
        state_nxt_s   = RESULT;
        win_nxt_s     = digits_match(held_r);
        buzz_nxt_s    = digits_match(held_r);
        buz_cnt_nxt_s = digits_match(held_r) ? BUZ_LOAD : BUZ_ZERO;
      end
      RESULT: begin
        if (btn_pulse_s) begin
          // a press also cuts short any buzz still running
          state_nxt_s   = RUN;
          reel_en_nxt_s = 3'b111;
          win_nxt_s     = 1'b0;
          buzz_nxt_s    = 1'b0;
          buz_cnt_nxt_s = BUZ_ZERO;
        end else if (buzz_r) begin
          if (buz_cnt_r == BUZ_ZERO) begin
            buzz_nxt_s = 1'b0;
          end else begin
            buz_cnt_nxt_s = buz_cnt_r - BUZ_ONE;
          end
        end else begin
          buz_cnt_nxt_s = BUZ_ZERO;
        end
      end
      default: begin
        state_nxt_s   = SET;
        reel_en_nxt_s = 3'b000;
        win_nxt_s     = 1'b0;
        buzz_nxt_s    = 1'b0;
        stg_cnt_nxt_s = STG_ZERO;
        buz_cnt_nxt_s = BUZ_ZERO;
      end
    endcase
  end

  assign reel_en  = reel_en_r;
  assign held_val = held_r;
  assign win      = win_r;
  assign buzzer   = buzz_r;
  assign state    = state_r;

endmodule
